// File: rtl/cronometro_regressivo_param_if.sv
// Control and display bundle of the shot-clock countdown.
// The master drives the switches; the slave (the timer) drives the display and status outputs.
interface cronometro_regressivo_param_if #(
  parameter int WIDTH = 5
);
  logic             chaveParar;
  logic             chave24;
  logic             chave14;
  logic [WIDTH-1:0] cronometro;
  logic [3:0]       dezenas;
  logic [3:0]       unidades;
  logic             rodando;
  logic             estourou;
  logic             buzina;

  modport master (
    output chaveParar, chave24, chave14,
    input  cronometro, dezenas, unidades, rodando, estourou, buzina
  );

  modport slave (
    input  chaveParar, chave24, chave14,
    output cronometro, dezenas, unidades, rodando, estourou, buzina
  );
endinterface

// File: rtl/cronometro_regressivo_param.sv
// Parametrised shot-clock countdown. A 1 Hz tick comes from an internal prescaler.
// Two reload values apply the 14-second rule; the clock freezes at zero with an expiry pulse and a timed buzzer.
module cronometro_regressivo_param #(
  parameter int PRESCALE    = 50_000_000,
  parameter int WIDTH       = 5,
  parameter int LOAD_A      = 24,
  parameter int LOAD_B      = 14,
  parameter int BUZZ_CYCLES = 50_000_000
) (
  input  logic                          clk,
  input  logic                          clr,
  cronometro_regressivo_param_if.slave  bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;

  localparam logic [PW-1:0]    PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [BW-1:0]    BUZZ_LAST = BW'(BUZZ_CYCLES - 1);
  localparam logic [WIDTH-1:0] CNT_A     = WIDTH'(LOAD_A);
  localparam logic [WIDTH-1:0] CNT_B     = WIDTH'(LOAD_B);

  typedef enum logic [1:0] {
    PAUSE,
    RUN,
    ZERO
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [BW-1:0]    buzz_cnt_q, buzz_cnt_d;
  logic             buzina_q, buzina_d;
  logic             estourou_q, estourou_d;
  logic             prev24_q, prev24_d;
  logic             prev14_q, prev14_d;

  logic load24, load14, tick;
  logic [6:0] bcd_val;

  assign load24 = bus.chave24 & ~prev24_q;
  // The short reload only counts as a load when it would raise the count.
  assign load14 = bus.chave14 & ~prev14_q & (count_q < CNT_B);
  assign tick   = (state_q == RUN) && (pre_q == PRE_LAST);

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pre_d      = pre_q;
    buzz_cnt_d = buzz_cnt_q;
    buzina_d   = buzina_q;
    estourou_d = 1'b0;
    prev24_d   = bus.chave24;
    prev14_d   = bus.chave14;

    // buzz_cnt holds the number of high cycles still to come after the current one.
    if (buzina_q) begin
      if (buzz_cnt_q == '0) buzina_d = 1'b0;
      else                  buzz_cnt_d = buzz_cnt_q - 1'b1;
    end

    if (load24 || load14) begin
      count_d    = load24 ? CNT_A : CNT_B;
      pre_d      = '0;
      buzina_d   = 1'b0;
      buzz_cnt_d = '0;
      state_d    = bus.chaveParar ? PAUSE : RUN;
    end else begin
      unique case (state_q)
        PAUSE: state_d = bus.chaveParar ? PAUSE : RUN;
        RUN: begin
          if (tick) begin
            pre_d = '0;
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - 1'b1;
              state_d = bus.chaveParar ? PAUSE : RUN;
            end else if (count_q == WIDTH'(1)) begin
              count_d    = '0;
              state_d    = ZERO;
              estourou_d = 1'b1;
              buzina_d   = 1'b1;
              buzz_cnt_d = BUZZ_LAST;
            end else begin
              state_d = ZERO;
            end
          end else begin
            pre_d   = pre_q + 1'b1;
            state_d = bus.chaveParar ? PAUSE : RUN;
          end
        end
        ZERO:    state_d = ZERO;
        default: state_d = PAUSE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= PAUSE;
      count_q    <= CNT_A;
      pre_q      <= '0;
      buzz_cnt_q <= '0;
      buzina_q   <= 1'b0;
      estourou_q <= 1'b0;
      prev24_q   <= 1'b0;
      prev14_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pre_q      <= pre_d;
      buzz_cnt_q <= buzz_cnt_d;
      buzina_q   <= buzina_d;
      estourou_q <= estourou_d;
      prev24_q   <= prev24_d;
      prev14_q   <= prev14_d;
    end
  end

  // The count never exceeds LOAD_A (at most 99), so seven bits are enough for the BCD split.
  assign bcd_val        = 7'(count_q);
  assign bus.dezenas    = 4'(bcd_val / 7'd10);
  assign bus.unidades   = 4'(bcd_val % 7'd10);
  assign bus.cronometro = count_q;
  assign bus.rodando    = (state_q == RUN);
  assign bus.estourou   = estourou_q;
  assign bus.buzina     = buzina_q;

endmodule

// File: tb/tb_cronometro_regressivo_param.sv
// Self-checking bench for cronometro_regressivo_param with PRESCALE=4 and BUZZ_CYCLES=3.
// A vector table is followed by hand-written sequences for exit from zero, a held button and the async reset.
module tb_cronometro_regressivo_param;

  localparam int WIDTH = 5;

  typedef struct {
    logic parar;
    logic c24;
    logic c14;
    int   n;
    int   cnt;
    logic rod;
    logic est;
    logic buz;
  } vec_t;

  typedef struct {
    int   cnt;
    logic rod;
    logic est;
    logic buz;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t vecs[26];

  cronometro_regressivo_param_if #(.WIDTH(WIDTH)) bus_if ();

  cronometro_regressivo_param #(
    .PRESCALE   (4),
    .WIDTH      (WIDTH),
    .LOAD_A     (24),
    .LOAD_B     (14),
    .BUZZ_CYCLES(3)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic c24, input logic c14);
    bus_if.chaveParar = p;
    bus_if.chave24    = c24;
    bus_if.chave14    = c14;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input int cnt, input logic rod, input logic est, input logic buz);
    exp_t e;
    e.cnt = cnt; e.rod = rod; e.est = est; e.buz = buz;
    sb.push_back(e);
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " cnt"}, 32'(bus_if.cronometro), 32'(e.cnt));
      check({tag, " dez"}, 32'(bus_if.dezenas),    32'(e.cnt / 10));
      check({tag, " uni"}, 32'(bus_if.unidades),   32'(e.cnt % 10));
      check({tag, " rod"}, 32'(bus_if.rodando),    32'(e.rod));
      check({tag, " est"}, 32'(bus_if.estourou),   32'(e.est));
      check({tag, " buz"}, 32'(bus_if.buzina),     32'(e.buz));
    end
  endtask

  initial begin
    // parar, c24, c14, cycles, count, rodando, estourou, buzina
    vecs[0]  = '{0, 0, 0,  1, 24, 1, 0, 0};
    vecs[1]  = '{0, 0, 0,  4, 23, 1, 0, 0};
    vecs[2]  = '{0, 0, 0,  4, 22, 1, 0, 0};
    vecs[3]  = '{0, 0, 0,  2, 22, 1, 0, 0};
    vecs[4]  = '{1, 0, 0, 10, 22, 0, 0, 0};
    vecs[5]  = '{0, 0, 0,  1, 22, 1, 0, 0};
    vecs[6]  = '{0, 0, 0,  1, 21, 1, 0, 0};
    vecs[7]  = '{0, 0, 0,  4, 20, 1, 0, 0};
    vecs[8]  = '{0, 0, 1,  1, 20, 1, 0, 0};
    vecs[9]  = '{0, 0, 0,  2, 20, 1, 0, 0};
    vecs[10] = '{0, 0, 0,  1, 19, 1, 0, 0};
    vecs[11] = '{0, 0, 0, 40,  9, 1, 0, 0};
    vecs[12] = '{0, 0, 1,  1, 14, 1, 0, 0};
    vecs[13] = '{0, 0, 1,  3, 14, 1, 0, 0};
    vecs[14] = '{0, 0, 1,  1, 13, 1, 0, 0};
    vecs[15] = '{0, 0, 0, 16,  9, 1, 0, 0};
    vecs[16] = '{0, 1, 1,  1, 24, 1, 0, 0};
    vecs[17] = '{0, 0, 0, 88,  2, 1, 0, 0};
    vecs[18] = '{0, 0, 0,  3,  2, 1, 0, 0};
    vecs[19] = '{0, 0, 0,  1,  1, 1, 0, 0};
    vecs[20] = '{0, 0, 0,  3,  1, 1, 0, 0};
    vecs[21] = '{0, 0, 0,  1,  0, 0, 1, 1};
    vecs[22] = '{0, 0, 0,  1,  0, 0, 0, 1};
    vecs[23] = '{0, 0, 0,  1,  0, 0, 0, 1};
    vecs[24] = '{0, 0, 0,  1,  0, 0, 0, 0};
    vecs[25] = '{0, 0, 0, 20,  0, 0, 0, 0};

    drive(0, 0, 0);
    #2 clr = 1'b1;
    #10;
    expect_out(24, 0, 0, 0);
    compare_out("reset");
    clr = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].parar, vecs[i].c24, vecs[i].c14);
      expect_out(vecs[i].cnt, vecs[i].rod, vecs[i].est, vecs[i].buz);
      step(vecs[i].n);
      compare_out($sformatf("v%0d", i));
    end

    // Leave ZERO through the short reload, then run back down to zero.
    drive(0, 0, 1);
    expect_out(14, 1, 0, 0);
    step(1);
    compare_out("zero_exit14");
    drive(0, 0, 0);
    expect_out(0, 0, 1, 1);
    step(56);
    compare_out("expire_again");

    // Full reload while the buzzer sounds, then keep the button held.
    drive(0, 1, 0);
    expect_out(24, 1, 0, 0);
    step(1);
    compare_out("reload_in_buzz");
    expect_out(22, 1, 0, 0);
    step(10);
    compare_out("held24");

    drive(0, 0, 0);
    expect_out(7, 1, 0, 0);
    step(58);
    compare_out("count7");

    // Asynchronous clear between clock edges.
    #2 clr = 1'b1;
    #1;
    expect_out(24, 0, 0, 0);
    compare_out("async_clr");
    step(2);
    expect_out(24, 0, 0, 0);
    compare_out("held_clr");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
